// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered program counter with return-address stack, stall, redirect and halt
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               hold PC and RAS this cycle (redirect still applies)
//   redirect            load redirect_pc, clear halted; highest priority
//   redirect_pc         redirect target
//   branch/call/ret/halt decoded control for the current instruction
//   cond, z, v, n       branch condition code and ALU flags
//   b_imm, c_imm        two's-complement branch / call offsets
//   ret_reg             fallback return address when the RAS is empty
//   pc                  current PC
//   halted              sticky halt status
//   ras_count           number of valid RAS entries
//   ras_ovf, ras_unf    sticky overflow / underflow flags

module pc_sequencer #(
  parameter int            AW       = 16,
  parameter int            DEPTH    = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     branch,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     halt,
  input  logic [2:0]               cond,
  input  logic                     z,
  input  logic                     v,
  input  logic                     n,
  input  logic [AW-1:0]            b_imm,
  input  logic [AW-1:0]            c_imm,
  input  logic [AW-1:0]            ret_reg,
  output logic [AW-1:0]            pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   ras_count,
  output logic                     ras_ovf,
  output logic                     ras_unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Circular stack: wr_ptr names the next slot to write, so the most recent
  // entry sits at wr_ptr-1. When full, wr_ptr has wrapped onto the oldest
  // entry, so a push naturally overwrites it.
  logic [AW-1:0] ras_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic [AW-1:0] pc_inc;
  logic          taken;
  logic          advance;
  logic          do_push;
  logic          ras_empty;
  logic          ras_full;

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = !z;
      3'b001:  taken = z;
      3'b010:  taken = !n && !z;
      3'b011:  taken = n;
      3'b100:  taken = z || !n;
      3'b101:  taken = n || z;
      3'b110:  taken = v;
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    pc_inc    = pc + AW'(1);
    top_ptr   = wr_ptr - PW'(1);
    ras_empty = (ras_count == '0);
    ras_full  = (ras_count == FULL_COUNT);
    // Normal instruction processing happens only when nothing higher-priority
    // (redirect, halted, stall) owns the cycle.
    advance   = !redirect && !halted && !stall;
    do_push   = advance && !branch && call;
  end

  // Stack contents need no reset; count and pointer define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[wr_ptr] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      halted    <= 1'b0;
      wr_ptr    <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      halted <= 1'b0;
    end else if (advance) begin
      if (branch) begin
        pc <= taken ? (pc_inc + b_imm) : pc_inc;
      end else if (call) begin
        pc     <= pc_inc + c_imm;
        wr_ptr <= wr_ptr + PW'(1);
        if (ras_full) begin
          ras_ovf <= 1'b1;
        end else begin
          ras_count <= ras_count + CW'(1);
        end
      end else if (ret) begin
        if (ras_empty) begin
          pc      <= ret_reg;
          ras_unf <= 1'b1;
        end else begin
          pc        <= ras_mem[top_ptr];
          wr_ptr    <= top_ptr;
          ras_count <= ras_count - CW'(1);
        end
      end else if (halt) begin
        halted <= 1'b1;
      end else begin
        pc <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a queue-based model

module tb_pc_sequencer;

  localparam int AW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          branch = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic          halt = 1'b0;
  logic [2:0]    cond = 3'b000;
  logic          z = 1'b0;
  logic          v = 1'b0;
  logic          n = 1'b0;
  logic [AW-1:0] b_imm = '0;
  logic [AW-1:0] c_imm = '0;
  logic [AW-1:0] ret_reg = '0;
  logic [AW-1:0] pc;
  logic          halted;
  logic [3:0]    ras_count;
  logic          ras_ovf;
  logic          ras_unf;

  pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .branch(branch), .call(call), .ret(ret),
    .halt(halt), .cond(cond), .z(z), .v(v), .n(n), .b_imm(b_imm),
    .c_imm(c_imm), .ret_reg(ret_reg), .pc(pc), .halted(halted),
    .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: PC as a plain 16-bit value, stack as a queue whose
  // front is the oldest entry and back the most recent.
  logic [AW-1:0] m_pc;
  logic          m_halted;
  logic          m_ovf;
  logic          m_unf;
  logic [AW-1:0] m_stack[$];

  function automatic logic cond_taken(input logic [2:0] c, input logic fz, input logic fv, input logic fn);
    case (c)
      3'd0: return !fz;
      3'd1: return fz;
      3'd2: return !fn && !fz;
      3'd3: return fn;
      3'd4: return fz || !fn;
      3'd5: return fn || fz;
      3'd6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    m_halted = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_step();
    if (redirect) begin
      m_pc = redirect_pc;
      m_halted = 1'b0;
    end else if (m_halted || stall) begin
      // nothing moves
    end else if (branch) begin
      m_pc = m_pc + 16'd1 + (cond_taken(cond, z, v, n) ? b_imm : 16'd0);
    end else if (call) begin
      m_stack.push_back(m_pc + 16'd1);
      if (m_stack.size() > DEPTH) begin
        void'(m_stack.pop_front());
        m_ovf = 1'b1;
      end
      m_pc = m_pc + 16'd1 + c_imm;
    end else if (ret) begin
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
      end else begin
        m_pc = ret_reg;
        m_unf = 1'b1;
      end
    end else if (halt) begin
      m_halted = 1'b1;
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".halted"}, 32'(halted), 32'(m_halted));
    check({tag, ".ras_count"}, 32'(ras_count), 32'(m_stack.size()));
    check({tag, ".ras_ovf"}, 32'(ras_ovf), 32'(m_ovf));
    check({tag, ".ras_unf"}, 32'(ras_unf), 32'(m_unf));
  endtask

  task automatic clear_ctrl();
    stall = 0; redirect = 0; branch = 0; call = 0; ret = 0; halt = 0;
  endtask

  // One clock: model consumes the current inputs, DUT sampled 1 time unit after the edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic go_to(input logic [AW-1:0] target);
    clear_ctrl();
    redirect = 1; redirect_pc = target;
    step("redirect");
    clear_ctrl();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.pc_const", 32'(pc), 32'h0);
    rst_n = 1;

    // Idle count-up from reset.
    for (int i = 1; i <= 4; i++) begin
      step("idle");
      check("idle.pc_const", 32'(pc), 32'(i));
    end

    // Branches.
    go_to(16'd10);
    branch = 1; cond = 3'b001; z = 1; b_imm = 16'd5;
    step("br_taken"); check("br_taken.const", 32'(pc), 32'd16);
    go_to(16'd10);
    branch = 1; cond = 3'b001; z = 0; b_imm = 16'd5;
    step("br_not"); check("br_not.const", 32'(pc), 32'd11);
    go_to(16'd10);
    branch = 1; cond = 3'b111; b_imm = 16'hFFFE;
    step("br_back"); check("br_back.const", 32'(pc), 32'd9);

    // Call / return / underflow.
    go_to(16'd20);
    call = 1; c_imm = 16'd30;
    step("call"); check("call.const", 32'(pc), 32'd51);
    clear_ctrl(); ret = 1;
    step("ret"); check("ret.const", 32'(pc), 32'd21);
    ret_reg = 16'd100;
    step("ret_unf"); check("ret_unf.const", 32'(pc), 32'd100);
    check("ret_unf.flag", 32'(ras_unf), 32'd1);

    // Overflow: 9 nested calls, then 9 returns.
    go_to(16'h0200);
    for (int i = 0; i < 9; i++) begin
      clear_ctrl(); call = 1; c_imm = 16'(i * 16 + 3);
      step("nest_call");
    end
    check("ovf.flag", 32'(ras_ovf), 32'd1);
    check("ovf.count", 32'(ras_count), 32'd8);
    ret_reg = 16'hBEEF;
    for (int i = 0; i < 9; i++) begin
      clear_ctrl(); ret = 1;
      step("nest_ret");
    end
    check("nest_ret9.const", 32'(pc), 32'hBEEF);

    // Halt is sticky until redirect; stall freezes call.
    go_to(16'd7);
    halt = 1;
    step("halt"); check("halt.const", 32'(pc), 32'd7);
    for (int i = 0; i < 4; i++) begin
      clear_ctrl(); branch = i[0]; call = ~i[0]; cond = 3'b111;
      step("halted_hold");
    end
    check("halted.flag", 32'(halted), 32'd1);
    go_to(16'd40);
    check("unhalt.const", 32'(pc), 32'd40);
    call = 1; stall = 1; c_imm = 16'd5;
    step("stall_call"); check("stall_call.const", 32'(pc), 32'd40);
    // Redirect wins over stall.
    clear_ctrl(); stall = 1; redirect = 1; redirect_pc = 16'h1234;
    step("stall_redirect");

    // Wrap and asynchronous reset.
    go_to(16'hFFFF);
    step("wrap"); check("wrap.const", 32'(pc), 32'h0);
    step("post_wrap");
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("async_reset");
    #1 rst_n = 1;

    // Randomized mix.
    for (int i = 0; i < 400; i++) begin
      clear_ctrl();
      redirect    = ($urandom_range(0, m_halted ? 3 : 15) == 0);
      redirect_pc = 16'($urandom);
      stall       = ($urandom_range(0, 7) == 0);
      branch      = ($urandom_range(0, 4) == 0);
      call        = ($urandom_range(0, 2) == 0);
      ret         = ($urandom_range(0, 2) == 0);
      halt        = ($urandom_range(0, 24) == 0);
      cond        = 3'($urandom);
      {z, v, n}   = 3'($urandom);
      b_imm       = 16'($urandom);
      c_imm       = 16'($urandom);
      ret_reg     = 16'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit for the fetch stage: holds the PC and, each cycle, resolves branch/call/return/halt decisions into the next PC. Generalises the combinational next-PC logic with a parametrised address width, an internal return-address stack (RAS) of configurable depth with overflow/underflow handling, pipeline stall, an external redirect, and a sticky halted state. Sits between the decode/flag logic and the instruction-memory address port.

## Interface

- AW, 16, PC / immediate width in bits
- DEPTH, 8, RAS entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all state this cycle (except redirect)
- redirect  in  1  force PC load, highest priority
- redirect_pc  in  AW  target for redirect
- branch, call, ret, halt  in  1 each  decoded control for the current instruction
- cond  in  3  branch condition code
- z, v, n  in  1 each  ALU flags
- b_imm, c_imm  in  AW  branch / call offsets (two's complement)
- ret_reg  in  AW  fallback return address used on RAS underflow
- pc  out  AW  current PC (registered)
- halted  out  1  sticky halt status
- ras_count  out  $clog2(DEPTH)+1  valid RAS entries
- ras_ovf, ras_unf  out  1 each  sticky overflow / underflow flags

## Operation

- Reset (async, rst_n=0): pc=RESET_PC, halted=0, ras_count=0, ras_ovf=0, ras_unf=0; RAS contents don't-care.
- Condition taken (cond): 000 !z; 001 z; 010 !n&&!z; 011 n; 100 z||!n; 101 n||z; 110 v; 111 always.
- Per-cycle priority, first match wins:
  1. redirect: pc<=redirect_pc, halted<=0; RAS unchanged.
  2. halted: pc held, nothing changes.
  3. stall: pc and RAS held.
  4. branch: taken → pc<=pc+1+b_imm; not taken → pc<=pc+1. call/ret/halt ignored.
  5. call: push pc+1; pc<=pc+1+c_imm.
  6. ret: RAS non-empty → pop, pc<=popped value; empty → pc<=ret_reg, ras_unf<=1.
  7. halt: pc held, halted<=1.
  8. otherwise pc<=pc+1.
- RAS is circular (write pointer + count). Push when ras_count<DEPTH: count+1. Push when full: overwrite oldest entry, count stays DEPTH, ras_ovf<=1. Pop returns most recent push.
- All PC arithmetic modulo 2^AW (wraps silently, e.g. AW=16: 16'hFFFF+1 → 16'h0000).
- ras_ovf/ras_unf clear only on reset.

## Timing

- Single-cycle: decisions sampled on rising edge; new pc visible after that edge. No combinational path from inputs to outputs.
- halt asserted in cycle N: halted=1 and pc frozen from edge N; further control inputs ignored until redirect or reset.
- redirect overrides stall and halted in the same cycle.
- Call then ret on consecutive cycles: ret returns the call's pc+1 (RAS write visible next cycle).
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously), independent of clk.

## Test plan

- Reset, 4 idle cycles, AW=16 → pc 0,1,2,3,4; flags 0; ras_count 0.
- pc=10, branch, cond=001, z=1, b_imm=5 → pc=16; same with z=0 → pc=11; cond=111, b_imm=16'hFFFE → pc=9.
- pc=20 call c_imm=30 → pc=51, ras_count=1; next ret → pc=21, ras_count=0; ret again, ret_reg=100 → pc=100, ras_unf=1.
- DEPTH=8: 9 nested calls → ras_ovf=1, ras_count=8; 8 rets return last 8 addresses in reverse order, 9th ret uses ret_reg.
- halt at pc=7 → pc stays 7, halted=1 while branch/call toggled; redirect_pc=40 → pc=40, halted=0; stall with call → pc and ras_count unchanged.
- pc=16'hFFFF, no control → pc=0; rst_n pulsed low between edges → pc=RESET_PC before next edge.
